// File: rtl/i2s_master_tx_if.sv
// Sample-pair handshake bundle between the filter back-end and i2s_master_tx.
//   lft_chnnl/rght_chnnl : 24-bit two's complement sample pair
//   vld                  : producer has a pair; taken when vld & rdy
//   rdy                  : transmitter holding register empty
//   undrflw              : one-clk pulse when a frame starts with nothing held
// master modport = sample producer, slave modport = transmitter.
interface i2s_master_tx_if;
    localparam int unsigned SAMPLE_W = 24;

    logic [SAMPLE_W-1:0] lft_chnnl;
    logic [SAMPLE_W-1:0] rght_chnnl;
    logic                vld;
    logic                rdy;
    logic                undrflw;

    modport master (
        output lft_chnnl,
        output rght_chnnl,
        output vld,
        input  rdy,
        input  undrflw
    );

    modport slave (
        input  lft_chnnl,
        input  rght_chnnl,
        input  vld,
        output rdy,
        output undrflw
    );
endinterface

// File: rtl/i2s_master_tx.sv
// Transmit-side I2S master: serializes 24-bit left/right pairs onto I2S_data
// with 24 slots per channel (48 per frame), MSB one slot after each I2S_ws edge.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   bus       : i2s_master_tx_if.slave sample handshake (pair in, rdy/undrflw out)
//   I2S_sclk  : bit clock, period 2*SCLK_DIV clks, 50% duty
//   I2S_ws    : word select, 0 = left, 1 = right
//   I2S_data  : serial data, changes on I2S_sclk fall
// Build option: define I2S_TX_ZERO_ON_UNDRFLW_EN to send silence on underflow;
// otherwise an underflow frame repeats the last successfully loaded pair.
module i2s_master_tx #(
    parameter int unsigned SCLK_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    i2s_master_tx_if.slave    bus,
    output logic              I2S_sclk,
    output logic              I2S_ws,
    output logic              I2S_data
);

    localparam int unsigned DIV_W     = $clog2(SCLK_DIV);
    localparam int unsigned SLOT_W    = 6;
    localparam int unsigned FRAME_W   = 48;
    localparam int unsigned LAST_SLOT = 47;
    localparam int unsigned WS_FIRST  = 23;
    localparam int unsigned WS_LAST   = 46;
    localparam int unsigned RST_SLOT  = 46;

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               sclk_q, sclk_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               ws_q, ws_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic               full_q, full_d;
    logic               undrflw_q, undrflw_d;
`ifndef I2S_TX_ZERO_ON_UNDRFLW_EN
    logic [FRAME_W-1:0] last_q, last_d;
`endif

    logic               div_tc;
    logic               fall_evt;
    logic               frame_load;
    logic               accept;
    logic [SLOT_W-1:0]  slot_nxt;
    logic [FRAME_W-1:0] undrflw_val;

    // Event decode from current state.
    always_comb begin
        div_tc     = (div_cnt_q == DIV_W'(SCLK_DIV - 1));
        fall_evt   = div_tc & sclk_q;
        slot_nxt   = (slot_q == SLOT_W'(LAST_SLOT)) ? '0 : slot_q + SLOT_W'(1);
        frame_load = fall_evt & (slot_nxt == '0);
        accept     = bus.vld & ~full_q;
`ifdef I2S_TX_ZERO_ON_UNDRFLW_EN
        undrflw_val = '0;
`else
        undrflw_val = last_q;
`endif
    end

    // Next-state logic for divider, slot counter, shifter and holding register.
    always_comb begin
        div_cnt_d = div_tc ? '0 : div_cnt_q + DIV_W'(1);
        sclk_d    = div_tc ? ~sclk_q : sclk_q;
        slot_d    = slot_q;
        ws_d      = ws_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        full_d    = full_q;
        undrflw_d = 1'b0;
`ifndef I2S_TX_ZERO_ON_UNDRFLW_EN
        last_d    = last_q;
`endif

        if (fall_evt) begin
            slot_d = slot_nxt;
            // ws leads the channel's MSB by one slot.
            ws_d   = (slot_nxt >= SLOT_W'(WS_FIRST)) && (slot_nxt <= SLOT_W'(WS_LAST));
            if (frame_load) begin
                if (full_q) begin
                    shift_d = hold_q;
                    full_d  = 1'b0;
`ifndef I2S_TX_ZERO_ON_UNDRFLW_EN
                    last_d  = hold_q;
`endif
                end else begin
                    shift_d   = undrflw_val;
                    undrflw_d = 1'b1;
                end
            end else begin
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
        end

        // Accept only when empty; a load in this cycle used the pre-write contents.
        if (accept) begin
            hold_d = {bus.lft_chnnl, bus.rght_chnnl};
            full_d = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
            slot_q    <= SLOT_W'(RST_SLOT);
            ws_q      <= 1'b1;
            shift_q   <= '0;
            hold_q    <= '0;
            full_q    <= 1'b0;
            undrflw_q <= 1'b0;
`ifndef I2S_TX_ZERO_ON_UNDRFLW_EN
            last_q    <= '0;
`endif
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
            slot_q    <= slot_d;
            ws_q      <= ws_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            undrflw_q <= undrflw_d;
`ifndef I2S_TX_ZERO_ON_UNDRFLW_EN
            last_q    <= last_d;
`endif
        end
    end

    assign I2S_sclk    = sclk_q;
    assign I2S_ws      = ws_q;
    assign I2S_data    = shift_q[FRAME_W-1];
    assign bus.rdy     = ~full_q;
    assign bus.undrflw = undrflw_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Directed bench for i2s_master_tx (SCLK_DIV = 16). A negedge monitor acts as
// the I2S receiver: it tracks the slot number from observed sclk falls,
// assembles each 48-slot frame (data and ws per slot) and notes undrflw.
module tb_i2s_master_tx;

    localparam int unsigned SCLK_DIV = 16;
    localparam int unsigned BUDGET   = 3000;
    localparam logic [47:0] WS_EXP   = 48'h0000_01FF_FFFE;

    typedef struct {
        logic [47:0] data;
        logic [47:0] ws;
        logic        unf;
    } frame_t;

    logic clk;
    logic rst;
    logic I2S_sclk;
    logic I2S_ws;
    logic I2S_data;

    i2s_master_tx_if bus ();

    i2s_master_tx #(.SCLK_DIV(SCLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .I2S_sclk (I2S_sclk),
        .I2S_ws   (I2S_ws),
        .I2S_data (I2S_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Receiver model state.
    frame_t      frames[$];
    int          mon_slot;
    logic        sclk_prev;
    logic        have_start;
    logic [47:0] cur_data;
    logic [47:0] cur_ws;
    logic        cur_unf;
    int          stray_unf;

    always @(negedge clk) begin
        logic   fall;
        frame_t f;
        if (rst) begin
            mon_slot   = 46;
            sclk_prev  = 1'b0;
            have_start = 1'b0;
            stray_unf  = 0;
            cur_data   = '0;
            cur_ws     = '0;
            cur_unf    = 1'b0;
            frames.delete();
        end else begin
            fall = sclk_prev && !I2S_sclk;
            if (fall) begin
                mon_slot = (mon_slot == 47) ? 0 : mon_slot + 1;
                if (mon_slot == 0) begin
                    have_start = 1'b1;
                    cur_unf    = bus.undrflw;
                end
                cur_data[47-mon_slot] = I2S_data;
                cur_ws[47-mon_slot]   = I2S_ws;
                if (mon_slot == 47 && have_start) begin
                    f.data = cur_data;
                    f.ws   = cur_ws;
                    f.unf  = cur_unf;
                    frames.push_back(f);
                end
            end
            if (bus.undrflw === 1'b1 && !(fall && mon_slot == 0))
                stray_unf++;
            sclk_prev = I2S_sclk;
        end
    end

    task automatic do_reset();
        rst     = 1'b1;
        bus.vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        int n = 0;
        while (bus.rdy !== 1'b1 && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.rdy !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_pair_timeout rdy=%b required 1", bus.rdy);
        end
        bus.lft_chnnl  = l;
        bus.rght_chnnl = r;
        bus.vld        = 1'b1;
        @(posedge clk);
        #1;
        bus.vld = 1'b0;
    endtask

    task automatic get_frame(output frame_t f);
        int n = 0;
        while (frames.size() == 0 && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (frames.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL get_frame_timeout frames=0 required >=1");
            f.data = 'x;
            f.ws   = 'x;
            f.unf  = 1'bx;
        end else begin
            f = frames.pop_front();
        end
    endtask

    task automatic chk_frame(input string name, input frame_t f,
                             input logic [47:0] exp_data, input logic exp_unf);
        n_cmp++;
        if (f.data !== exp_data) begin
            n_err++;
            $display("FAIL %s_data got=%h required=%h", name, f.data, exp_data);
        end
        n_cmp++;
        if (f.ws !== WS_EXP) begin
            n_err++;
            $display("FAIL %s_ws got=%h required=%h", name, f.ws, WS_EXP);
        end
        n_cmp++;
        if (f.unf !== exp_unf) begin
            n_err++;
            $display("FAIL %s_undrflw got=%b required=%b", name, f.unf, exp_unf);
        end
    endtask

    task automatic chk_stray(input string name);
        n_cmp++;
        if (stray_unf !== 0) begin
            n_err++;
            $display("FAIL %s_stray_undrflw got=%0d required=0", name, stray_unf);
        end
    endtask

    task automatic test_reset();
        int rise_at = -1;
        int fall_at = -1;
        int wsf_at  = -1;
        logic [4:0] got;
        rst     = 1'b1;
        bus.vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        got = {I2S_sclk, I2S_ws, I2S_data, bus.rdy, bus.undrflw};
        n_cmp++;
        if (got !== 5'b01010) begin
            n_err++;
            $display("FAIL reset_outputs {sclk,ws,data,rdy,unf} got=%b required=01010", got);
        end
        rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (I2S_sclk === 1'b1 && rise_at < 0) rise_at = n;
            if (I2S_sclk === 1'b0 && rise_at >= 0 && fall_at < 0) fall_at = n;
            if (I2S_ws === 1'b0 && wsf_at < 0) wsf_at = n;
        end
        n_cmp++;
        if (rise_at != SCLK_DIV) begin
            n_err++;
            $display("FAIL reset_first_rise got=%0d required=%0d", rise_at, SCLK_DIV);
        end
        n_cmp++;
        if (fall_at != 2 * SCLK_DIV) begin
            n_err++;
            $display("FAIL reset_first_fall got=%0d required=%0d", fall_at, 2 * SCLK_DIV);
        end
        n_cmp++;
        if (wsf_at != 2 * SCLK_DIV) begin
            n_err++;
            $display("FAIL reset_ws_fall got=%0d required=%0d", wsf_at, 2 * SCLK_DIV);
        end
    endtask

    task automatic test_single_frame();
        frame_t f;
        do_reset();
        send_pair(24'hA5A5A5, 24'h3C3C3C);
        n_cmp++;
        if (bus.rdy !== 1'b0) begin
            n_err++;
            $display("FAIL single_rdy_after_accept got=%b required=0", bus.rdy);
        end
        get_frame(f);
        chk_frame("single", f, {24'hA5A5A5, 24'h3C3C3C}, 1'b0);
        n_cmp++;
        if (bus.rdy !== 1'b1) begin
            n_err++;
            $display("FAIL single_rdy_after_load got=%b required=1", bus.rdy);
        end
        chk_stray("single");
    endtask

    task automatic test_loopback();
        frame_t      f;
        logic [23:0] l;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            l = 24'h000001 << n;
            send_pair(l, ~l);
        end
        for (int n = 0; n < 8; n++) begin
            l = 24'h000001 << n;
            get_frame(f);
            chk_frame($sformatf("loop%0d", n), f, {l, ~l}, 1'b0);
        end
        chk_stray("loop");
    endtask

    task automatic test_underflow();
        frame_t      f;
        logic [47:0] exp2;
        do_reset();
        get_frame(f);
        chk_frame("unf_frame0", f, 48'h0, 1'b1);
        send_pair(24'h7FFFFF, 24'h123456);
        get_frame(f);
        chk_frame("unf_frame1", f, {24'h7FFFFF, 24'h123456}, 1'b0);
`ifdef I2S_TX_ZERO_ON_UNDRFLW_EN
        exp2 = 48'h0;
`else
        exp2 = {24'h7FFFFF, 24'h123456};
`endif
        get_frame(f);
        chk_frame("unf_frame2", f, exp2, 1'b1);
        chk_stray("unf");
    endtask

    task automatic test_drop_when_full();
        frame_t      f;
        logic [47:0] exp1;
        do_reset();
        send_pair(24'h111111, 24'h222222);
        bus.lft_chnnl  = 24'h333333;
        bus.rght_chnnl = 24'h444444;
        bus.vld        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.vld = 1'b0;
        n_cmp++;
        if (bus.rdy !== 1'b0) begin
            n_err++;
            $display("FAIL drop_rdy_held got=%b required=0", bus.rdy);
        end
        get_frame(f);
        chk_frame("drop_frame0", f, {24'h111111, 24'h222222}, 1'b0);
`ifdef I2S_TX_ZERO_ON_UNDRFLW_EN
        exp1 = 48'h0;
`else
        exp1 = {24'h111111, 24'h222222};
`endif
        get_frame(f);
        chk_frame("drop_frame1", f, exp1, 1'b1);
        chk_stray("drop");
    endtask

    task automatic test_vld_at_underflow_load();
        frame_t f;
        do_reset();
        // Frame 0 loads at edge 4*SCLK_DIV after release; present vld exactly there.
        repeat (4 * SCLK_DIV - 1) @(posedge clk);
        #1;
        bus.lft_chnnl  = 24'hC0FFEE;
        bus.rght_chnnl = 24'h0BEEF0;
        bus.vld        = 1'b1;
        @(posedge clk);
        #1;
        bus.vld = 1'b0;
        n_cmp++;
        if (bus.undrflw !== 1'b1) begin
            n_err++;
            $display("FAIL coincide_undrflw got=%b required=1", bus.undrflw);
        end
        n_cmp++;
        if (bus.rdy !== 1'b0) begin
            n_err++;
            $display("FAIL coincide_rdy got=%b required=0", bus.rdy);
        end
        get_frame(f);
        chk_frame("coincide_frame0", f, 48'h0, 1'b1);
        get_frame(f);
        chk_frame("coincide_frame1", f, {24'hC0FFEE, 24'h0BEEF0}, 1'b0);
        chk_stray("coincide");
    endtask

    initial begin
        rst            = 1'b1;
        bus.vld        = 1'b0;
        bus.lft_chnnl  = '0;
        bus.rght_chnnl = '0;
        test_reset();
        test_single_frame();
        test_loopback();
        test_underflow();
        test_drop_when_full();
        test_vld_at_underflow_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_master_tx.md
# i2s_master_tx

- Transmit-side I2S master for the equalizer datapath.
- Takes 24-bit left/right sample pairs from the filter back-end and serializes them onto `I2S_data`.
- Generates the bit clock `I2S_sclk` and word select `I2S_ws` from the system clock.
- Framing matches the team's I2S slave receiver: 24 bit-slots per channel, 48 per frame, MSB one slot after each `I2S_ws` edge. That makes the block directly loop-back testable against the receiver.

## Interface
Parameters:
- `SCLK_DIV`, default 16: `clk` cycles per `I2S_sclk` half-period. Legal values are 4 or more, so the receiver's 2-flop synchronizer can see every level.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `lft_chnnl`  in  24  left sample, two's complement.
- `rght_chnnl`  in  24  right sample, two's complement.
- `vld`  in  1  sample pair present; captured when `vld & rdy`.
- `rdy`  out  1  holding register empty; can accept a pair.
- `undrflw`  out  1  one-`clk` pulse when a frame starts with the holding register empty.
- `I2S_sclk`  out  1  bit clock, 50% duty, period `2*SCLK_DIV` clks.
- `I2S_ws`  out  1  word select; 0 = left, 1 = right.
- `I2S_data`  out  1  serial data; changes on `I2S_sclk` fall.

## Operation
- **Divider:** `div_cnt` counts 0..`SCLK_DIV`-1. At terminal count, `I2S_sclk` toggles and `div_cnt` wraps to 0. A "fall event" is the `clk` cycle in which `I2S_sclk` toggles 1→0.
- **Slot counter:** `slot` (6 bits) counts 0..47 and advances on each fall event, wrapping 47→0.
- **Word select:** `I2S_ws` is registered and updated on fall events from the new slot value.
  - `I2S_ws` = 1 for slots 23..46.
  - `I2S_ws` = 0 for slot 47 and slots 0..22.
- **Slot contents:**
  - Slot b (0..23) carries `lft` bit 23-b.
  - Slot b (24..47) carries `rght` bit 47-b.
- **Shift register (48 bits):** `I2S_data` is its MSB.
  - On the fall event entering slot 0, it loads `{hold_lft, hold_rght}`.
  - On every other fall event, it shifts left one bit and fills with 0.
- **Holding register:** 48 bits plus a `full` flag; `rdy` = `~full`.
  - `vld & rdy` writes the register and sets `full`.
  - `vld` while `full` is ignored; no overwrite.
- **Frame load:** on the fall event entering slot 0:
  - If `full`: the shift register takes the holding contents and `full` clears.
  - Else: the shift register loads the underflow value (see Configuration) and `undrflw` pulses in that cycle.
- **Simultaneous `vld & rdy` with an underflow frame load:**
  - The load sees the pre-write holding contents, so it is an underflow.
  - The new pair is captured, `full` = 1 next cycle, and it is used at the next frame.

## Timing
- **Reset values:** `I2S_sclk`=0, `I2S_ws`=1, `I2S_data`=0, `rdy`=1, `undrflw`=0, `div_cnt`=0, `slot`=46, holding and shift registers = 0.
- **After `rst` deasserts:**
  - First `I2S_sclk` rise at `clk` edge `SCLK_DIV`.
  - First fall at `2*SCLK_DIV`, entering slot 47, with `I2S_ws` falling.
  - Frame 0 loads at `4*SCLK_DIV`.
- **First frame after reset:** underflows unless `vld` was accepted at least one cycle before that edge.
- **Output change points:** `I2S_ws` and `I2S_data` change only in fall-event cycles, so they are stable for a full `SCLK_DIV` clks around each rise.
- **Latency:** a pair accepted in cycle t is first driven (left MSB) at the next slot-0 fall event strictly after t.
- **Frame period:** `96*SCLK_DIV` clks.
- **`rdy` timing:** `rdy` returns high the cycle after a successful frame load, giving one full frame to supply the next pair.
- **Mid-operation reset:** `rst` asserted at any point restores all reset values on the next edge; no partial frame completes.

## Configuration
- Macro `I2S_TX_ZERO_ON_UNDRFLW_EN`.
- **Defined:** an underflow frame loads 48'h0, so both channels transmit silence.
- **Undefined:** an underflow frame reloads the last successfully loaded pair (repeat-last). That value is 0 if none has loaded since reset.
- `undrflw` pulses identically in both builds.

## Test plan
- **Reset values:** hold `rst` 5 cycles → every output at its reset value; `I2S_sclk` period 32 clks after release (`SCLK_DIV`=16).
- **Single frame:** `vld` with `lft`=24'hA5A5A5 and `rght`=24'h3C3C3C before frame 0 → `I2S_data` slots 0..23 = A5A5A5 MSB-first and slots 24..47 = 3C3C3C. `I2S_ws` rises at slot 23, falls at slot 47, and `undrflw` stays 0.
- **Loopback:** tie the outputs to the I2S slave receiver and stream 8 pairs (left = 24'h000001<<n, right = ~left) → the receiver's `vld` fires 8 times with matching `lft_chnnl`/`rght_chnnl`.
- **Underflow, macro defined:** supply frame 1 only, with `lft`=24'h7FFFFF → frame 2 transmits all zeros and `undrflw` pulses once at the slot-0 fall event.
- **Underflow, macro undefined:** same stimulus as above → frame 2 repeats 24'h7FFFFF/right value; `undrflw` pulses once.
- **Edge cases:**
  - `vld` while `rdy`=0 → the pair is dropped and the previously held pair is sent.
  - `vld` in the exact underflow load cycle → that frame underflows and the next frame carries the new pair.
